pipelined_cla_subtractor: RTL and testbench

- Computes `d_out = a_in - b_in - bw_in` over NUMBITS, with borrow-out and signed-overflow flags.
- Built as a pipeline of 4-bit carry-lookahead slices, one slice per stage, so each cycle's critical path is a single 4-bit CLA.
- Sits beside the combinational n-bit CLA adder in the arithmetic datapath, for wide operands at high clock rates.
- Valid/ready handshake on both sides.

---
 rtl/arith_pkg.sv | 26 ++
 rtl/cla_sub_stage.sv | 55 +++++
 rtl/pipelined_cla_subtractor.sv | 75 +++++++
 tb/tb_pipelined_cla_subtractor.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic helpers: 4-bit carry-lookahead slice used by the adder and subtractor datapaths.
// Latency: combinational function only. Backpressure: not applicable.
// The slice width and type are shared so every CLA user agrees on the slice boundary.
package arith_pkg;

    localparam int BASE_SLICE_W = 4;

    typedef logic [BASE_SLICE_W-1:0] slice_t;

    // Returns {cout, sum}. Every carry is expanded from generate/propagate terms, so no ripple.
    function automatic logic [BASE_SLICE_W:0] cla4_sum(slice_t a, slice_t b, logic cin);
        slice_t                g;
        slice_t                p;
        logic [BASE_SLICE_W:0] c;
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        return {c[4], p ^ c[3:0]};
    endfunction

endpackage

// File: rtl/cla_sub_stage.sv
// One subtractor pipeline stage: a single 4-bit CLA on the lowest pending slice.
// Latency: 1 cycle. Backpressure: all registers hold while adv is low.
// Operand/result word rotates right one slice per stage, so after the last stage it is the aligned difference.
module cla_sub_stage
    import arith_pkg::*;
#(
    parameter int NUMBITS = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               adv,
    input  logic               vld_d,
    input  logic               bw_d,
    input  logic               a_msb_d,
    input  logic [NUMBITS-1:0] ad_d,
    input  logic [NUMBITS-1:0] nb_d,
    output logic               vld_q,
    output logic               bw_q,
    output logic               a_msb_q,
    output logic [NUMBITS-1:0] ad_q,
    output logic [NUMBITS-1:0] nb_q
);

    logic [BASE_SLICE_W:0] cs;
    logic [NUMBITS-1:0]    ad_nxt;
    logic [NUMBITS-1:0]    nb_nxt;

    // Borrow is stored inverted from carry so a cleared register means "no borrow".
    assign cs = cla4_sum(ad_d[BASE_SLICE_W-1:0], nb_d[BASE_SLICE_W-1:0], ~bw_d);

    if (NUMBITS > BASE_SLICE_W) begin : g_rot
        assign ad_nxt = {cs[BASE_SLICE_W-1:0], ad_d[NUMBITS-1:BASE_SLICE_W]};
        assign nb_nxt = {nb_d[BASE_SLICE_W-1:0], nb_d[NUMBITS-1:BASE_SLICE_W]};
    end else begin : g_single
        assign ad_nxt = cs[BASE_SLICE_W-1:0];
        assign nb_nxt = nb_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q   <= 1'b0;
            bw_q    <= 1'b0;
            a_msb_q <= 1'b0;
            ad_q    <= '0;
            nb_q    <= '0;
        end else if (adv) begin
            vld_q   <= vld_d;
            bw_q    <= ~cs[BASE_SLICE_W];
            a_msb_q <= a_msb_d;
            ad_q    <= ad_nxt;
            nb_q    <= nb_nxt;
        end
    end

endmodule

// File: rtl/pipelined_cla_subtractor.sv
// Pipelined subtractor d = a - b - bw_in, one 4-bit CLA slice per stage, with borrow and signed overflow.
// Latency: NUMBITS/4 cycles, one result per cycle. Backpressure: whole pipe freezes while
// out_valid && !out_ready; in_ready is the combinational inverse of that stall.
module pipelined_cla_subtractor
    import arith_pkg::*;
#(
    parameter int NUMBITS = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NUMBITS-1:0] a_in,
    input  logic [NUMBITS-1:0] b_in,
    input  logic               bw_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUMBITS-1:0] d_out,
    output logic               bw_out,
    output logic               ovf_out
);

    localparam int STAGES = NUMBITS / BASE_SLICE_W;

    if (NUMBITS == 0 || (NUMBITS % BASE_SLICE_W) != 0) begin : g_bad_width
        $error("pipelined_cla_subtractor: NUMBITS must be a non-zero multiple of 4");
    end

    logic               stall;
    logic [STAGES:0]    vld;
    logic [STAGES:0]    bw;
    logic [STAGES:0]    a_msb;
    logic [NUMBITS-1:0] ad [STAGES+1];
    logic [NUMBITS-1:0] nb [STAGES+1];
    logic [NUMBITS-2:0] nb_tail_unused;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    assign vld[0]   = in_valid & in_ready;
    assign bw[0]    = bw_in;
    assign a_msb[0] = a_in[NUMBITS-1];
    assign ad[0]    = a_in;
    assign nb[0]    = ~b_in;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        cla_sub_stage #(
            .NUMBITS (NUMBITS)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .adv     (~stall),
            .vld_d   (vld[k]),
            .bw_d    (bw[k]),
            .a_msb_d (a_msb[k]),
            .ad_d    (ad[k]),
            .nb_d    (nb[k]),
            .vld_q   (vld[k+1]),
            .bw_q    (bw[k+1]),
            .a_msb_q (a_msb[k+1]),
            .ad_q    (ad[k+1]),
            .nb_q    (nb[k+1])
        );
    end

    // After a full rotation nb holds ~b again; only its MSB feeds overflow.
    assign nb_tail_unused = nb[STAGES][NUMBITS-2:0];

    assign out_valid = vld[STAGES];
    assign d_out     = ad[STAGES];
    assign bw_out    = bw[STAGES];
    assign ovf_out   = (a_msb[STAGES] == nb[STAGES][NUMBITS-1])
                     & (ad[STAGES][NUMBITS-1] != a_msb[STAGES]);

endmodule

// File: tb/tb_pipelined_cla_subtractor.sv
// Self-checking bench for pipelined_cla_subtractor: directed vectors, stall/reset sequences,
// a 16-bit latency case and randomized traffic against an arithmetic reference model.
module tb_pipelined_cla_subtractor;

    logic       clk;
    logic       reset;
    logic       in_valid, in_ready, bw_in, out_valid, out_ready, bw_out, ovf_out;
    logic [7:0] a_in, b_in, d_out;

    logic        in_valid16, in_ready16, out_valid16, bw_out16, ovf_out16;
    logic [15:0] a16, b16, d16;

    pipelined_cla_subtractor #(.NUMBITS(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .bw_in     (bw_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d_out     (d_out),
        .bw_out    (bw_out),
        .ovf_out   (ovf_out)
    );

    pipelined_cla_subtractor #(.NUMBITS(16)) dut16 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .a_in      (a16),
        .b_in      (b16),
        .bw_in     (1'b0),
        .out_valid (out_valid16),
        .out_ready (1'b1),
        .d_out     (d16),
        .bw_out    (bw_out16),
        .ovf_out   (ovf_out16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bw;
        logic [7:0] d;
        logic       bwo;
        logic       ovf;
    } vec_t;

    vec_t       vecs [7];
    int         checks = 0;
    int         failures = 0;
    int         delivered = 0;
    logic [9:0] exp_q [$];
    logic       hold_pend = 1'b0;
    logic [9:0] hold_val = '0;

    // Reference: plain integer subtraction; borrow from the unsigned result sign,
    // overflow from the signed result leaving the 8-bit range. Packed as {bw, ovf, d}.
    function automatic logic [9:0] model(logic [7:0] a, logic [7:0] b, logic bw);
        int ud;
        int sd;
        ud = int'(a) - int'(b) - (bw ? 1 : 0);
        sd = int'($signed(a)) - int'($signed(b)) - (bw ? 1 : 0);
        return {ud < 0, (sd < -128) || (sd > 127), ud[7:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock of handshake traffic, called at a negedge; scores the transfers of the next posedge.
    task automatic cycle(input logic iv, input logic [7:0] a, input logic [7:0] b,
                         input logic bw, input logic ordy, output logic acc);
        logic [9:0] exp;
        in_valid  = iv;
        a_in      = a;
        b_in      = b;
        bw_in     = bw;
        out_ready = ordy;
        #1;
        if (hold_pend) begin
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_data", {22'd0, bw_out, ovf_out, d_out}, {22'd0, hold_val});
        end
        if (out_valid && !out_ready)
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL stale_result: got d=%0h with nothing expected", d_out);
            end else begin
                exp = exp_q.pop_front();
                check("result", {22'd0, bw_out, ovf_out, d_out}, {22'd0, exp});
                delivered++;
            end
        end
        acc = in_valid && in_ready;
        if (acc) exp_q.push_back(model(a, b, bw));
        hold_pend = out_valid && !out_ready;
        hold_val  = {bw_out, ovf_out, d_out};
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic       acc;
        logic [7:0] ra, rb;
        logic       rbw, ordy;
        int         sent, stall_left, d0, nacc;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h0F, 8'h01, 1'b0, 8'h0E, 1'b0, 1'b0};
        vecs[3] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};

        reset = 1'b1;
        in_valid = 1'b0; a_in = '0; b_in = '0; bw_in = 1'b0; out_ready = 1'b1;
        in_valid16 = 1'b0; a16 = '0; b16 = '0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_outputs", {22'd0, bw_out, ovf_out, d_out}, 32'd0);
        check("rst16_in_ready", {31'd0, in_ready16}, 32'd1);
        @(negedge clk);
        reset = 1'b0;

        // 16-bit: borrow ripples across three slice boundaries, result after 4 edges.
        in_valid16 = 1'b1; a16 = 16'h1000; b16 = 16'h0001;
        @(posedge clk);
        #1 in_valid16 = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            @(negedge clk);
            check("lat16_valid", {31'd0, out_valid16}, (e == 4) ? 32'd1 : 32'd0);
        end
        check("d16", {16'd0, d16}, 32'h0FFF);
        check("flags16", {30'd0, bw_out16, ovf_out16}, 32'd0);

        // Directed table: accept at one edge, expect valid exactly two edges later.
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; a_in = vecs[i].a; b_in = vecs[i].b; bw_in = vecs[i].bw; out_ready = 1'b1;
            @(posedge clk);
            #1 in_valid = 1'b0;
            @(negedge clk);
            check("lat_early", {31'd0, out_valid}, 32'd0);
            @(negedge clk);
            check("lat_valid", {31'd0, out_valid}, 32'd1);
            check("vec_d", {24'd0, d_out}, {24'd0, vecs[i].d});
            check("vec_bw", {31'd0, bw_out}, {31'd0, vecs[i].bwo});
            check("vec_ovf", {31'd0, ovf_out}, {31'd0, vecs[i].ovf});
        end
        @(posedge clk);
        @(negedge clk);
        check("drained_after_table", {31'd0, out_valid}, 32'd0);

        // Six back-to-back ops, consumer stalls 3 cycles once the first result appears.
        sent = 0; stall_left = 3; d0 = delivered;
        for (int c = 0; c < 40 && (sent < 6 || exp_q.size() > 0); c++) begin
            ordy = 1'b1;
            if (out_valid && stall_left > 0) begin
                ordy = 1'b0;
                stall_left--;
            end
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rbw = 1'($urandom_range(0, 1));
            cycle(sent < 6, ra, rb, rbw, ordy, acc);
            if (acc) sent++;
        end
        check("stream_delivered", delivered - d0, 32'd6);
        check("stream_stalled", stall_left, 32'd0);

        // Asynchronous reset between edges with two ops in flight.
        cycle(1'b1, 8'h44, 8'h11, 1'b0, 1'b1, acc);
        cycle(1'b1, 8'h22, 8'h33, 1'b0, 1'b1, acc);
        in_valid = 1'b0;
        check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_outputs", {22'd0, bw_out, ovf_out, d_out}, 32'd0);
        check("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
        exp_q.delete();
        hold_pend = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        d0 = delivered;
        cycle(1'b1, 8'h3C, 8'h5A, 1'b1, 1'b1, acc);
        for (int c = 0; c < 4; c++) cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc);
        check("post_reset_delivered", delivered - d0, 32'd1);

        // Random traffic with random source and sink throttling.
        nacc = 0;
        for (int c = 0; c < 60000 && nacc < 10000; c++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rbw = 1'($urandom_range(0, 1));
            cycle($urandom_range(0, 3) != 0, ra, rb, rbw, $urandom_range(0, 3) != 0, acc);
            if (acc) nacc++;
        end
        check("random_accepted", nacc, 32'd10000);
        for (int c = 0; c < 8 && exp_q.size() > 0; c++)
            cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc);
        check("random_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
